in_decode: RTL and testbench

Instruction-decode stage of the 5-stage RV32I core, between the IF/ID and ID/EX pipeline registers. Holds the 32×32 register file, decodes the incoming instruction into control signals, generates the sign-extended immediate, reads both source operands and optionally computes the branch target. The write-back stage drives the register-file write port.

---
 rtl/in_decode_pkg.sv | 31 +++
 rtl/in_decode_register_file.sv | 43 ++++
 rtl/in_decode.sv | 107 ++++++++++
 tb/tb_in_decode.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/in_decode_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, ALU operation
// classes and the control bundle handed to the ID/EX register.
package in_decode_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD = 2'b00,
    ALUOP_SUB = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    alu_op_e alu_op;
  } ctl_t;

endpackage

// File: rtl/in_decode_register_file.sv
// 32x32 register file: two combinational read ports, one write port and a
// synchronous reset, both taking effect on the falling clock edge.
module register_file
  import in_decode_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  // Falling-edge update lets write-back land within the cycle it is issued,
  // so decode sees the new value in the second half without a bypass.
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/in_decode.sv
// RV32I instruction-decode stage: control decode, immediate generation and
// register reads. Define ID_BRANCH_TARGET_EN to add the Branch_target adder.
module in_decode
  import in_decode_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Ctl_RegWrite_in,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic [31:0] PC_in,
  input  logic [31:0] instruction_in,
  output logic [31:0] PC_out,
  output logic [31:0] Read_data1,
  output logic [31:0] Read_data2,
  output logic [31:0] Immediate,
  output logic [4:0]  Rd,
  output logic [2:0]  Funct3,
  output logic        Funct7_5,
  output logic        Ctl_RegWrite_out,
  output logic        Ctl_ALUSrc_out,
  output logic        Ctl_MemRead_out,
  output logic        Ctl_MemWrite_out,
  output logic        Ctl_MemtoReg_out,
  output logic        Ctl_Branch_out,
`ifdef ID_BRANCH_TARGET_EN
  output logic [31:0] Branch_target,
`endif
  output logic [1:0]  Ctl_ALUOp_out
);

  logic [6:0]  opcode;
  ctl_t        ctl;
  logic [31:0] imm;

  assign opcode = instruction_in[6:0];

  always_comb begin
    ctl = '0;
    imm = '0;
    // Unrecognised (or unknown) opcodes fall to the default: a bubble.
    case (opcode)
      OP_R: begin
        ctl.reg_write = 1'b1;
        ctl.alu_op    = ALUOP_R;
      end
      OP_I: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.alu_op    = ALUOP_I;
        imm           = {{20{instruction_in[31]}}, instruction_in[31:20]};
      end
      OP_LOAD: begin
        ctl.reg_write  = 1'b1;
        ctl.alu_src    = 1'b1;
        ctl.mem_read   = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.alu_op     = ALUOP_ADD;
        imm            = {{20{instruction_in[31]}}, instruction_in[31:20]};
      end
      OP_STORE: begin
        ctl.alu_src   = 1'b1;
        ctl.mem_write = 1'b1;
        ctl.alu_op    = ALUOP_ADD;
        imm           = {{20{instruction_in[31]}}, instruction_in[31:25],
                         instruction_in[11:7]};
      end
      OP_BRANCH: begin
        ctl.branch = 1'b1;
        ctl.alu_op = ALUOP_SUB;
        imm        = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                      instruction_in[30:25], instruction_in[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  register_file u_register_file (
    .clk    (clk),
    .reset  (reset),
    .we     (Ctl_RegWrite_in),
    .waddr  (WriteReg),
    .wdata  (WriteData),
    .raddr1 (instruction_in[19:15]),
    .raddr2 (instruction_in[24:20]),
    .rdata1 (Read_data1),
    .rdata2 (Read_data2)
  );

  assign PC_out           = PC_in;
  assign Immediate        = imm;
  assign Rd               = instruction_in[11:7];
  assign Funct3           = instruction_in[14:12];
  assign Funct7_5         = instruction_in[30];
  assign Ctl_RegWrite_out = ctl.reg_write;
  assign Ctl_ALUSrc_out   = ctl.alu_src;
  assign Ctl_MemRead_out  = ctl.mem_read;
  assign Ctl_MemWrite_out = ctl.mem_write;
  assign Ctl_MemtoReg_out = ctl.mem_to_reg;
  assign Ctl_Branch_out   = ctl.branch;
  assign Ctl_ALUOp_out    = ctl.alu_op;

`ifdef ID_BRANCH_TARGET_EN
  assign Branch_target = PC_in + imm;
`endif

endmodule

// File: tb/tb_in_decode.sv
// Self-checking bench for in_decode: directed test-plan steps followed by
// randomized writes/instructions checked against a behavioural model.
module tb_in_decode;

  logic        clk;
  logic        reset;
  logic        Ctl_RegWrite_in;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [31:0] PC_in;
  logic [31:0] instruction_in;
  logic [31:0] PC_out;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic [31:0] Immediate;
  logic [4:0]  Rd;
  logic [2:0]  Funct3;
  logic        Funct7_5;
  logic        Ctl_RegWrite_out;
  logic        Ctl_ALUSrc_out;
  logic        Ctl_MemRead_out;
  logic        Ctl_MemWrite_out;
  logic        Ctl_MemtoReg_out;
  logic        Ctl_Branch_out;
  logic [1:0]  Ctl_ALUOp_out;
`ifdef ID_BRANCH_TARGET_EN
  logic [31:0] Branch_target;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] model_rf [32];

  in_decode dut (
    .clk              (clk),
    .reset            (reset),
    .Ctl_RegWrite_in  (Ctl_RegWrite_in),
    .WriteReg         (WriteReg),
    .WriteData        (WriteData),
    .PC_in            (PC_in),
    .instruction_in   (instruction_in),
    .PC_out           (PC_out),
    .Read_data1       (Read_data1),
    .Read_data2       (Read_data2),
    .Immediate        (Immediate),
    .Rd               (Rd),
    .Funct3           (Funct3),
    .Funct7_5         (Funct7_5),
    .Ctl_RegWrite_out (Ctl_RegWrite_out),
    .Ctl_ALUSrc_out   (Ctl_ALUSrc_out),
    .Ctl_MemRead_out  (Ctl_MemRead_out),
    .Ctl_MemWrite_out (Ctl_MemWrite_out),
    .Ctl_MemtoReg_out (Ctl_MemtoReg_out),
    .Ctl_Branch_out   (Ctl_Branch_out),
`ifdef ID_BRANCH_TARGET_EN
    .Branch_target    (Branch_target),
`endif
    .Ctl_ALUOp_out    (Ctl_ALUOp_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: controls as {RegWrite,ALUSrc,MemRead,MemWrite,MemtoReg,Branch,ALUOp}
  function automatic logic [7:0] ref_ctl(input logic [31:0] inst);
    case (inst[6:0])
      7'b0110011: return 8'b100000_10;
      7'b0010011: return 8'b110000_11;
      7'b0000011: return 8'b111010_00;
      7'b0100011: return 8'b010100_00;
      7'b1100011: return 8'b000001_01;
      default:    return 8'b000000_00;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] inst);
    int v;
    case (inst[6:0])
      7'b0010011, 7'b0000011: v = int'($signed(inst[31:20]));
      7'b0100011: v = int'($signed({inst[31:25], inst[11:7]}));
      7'b1100011: v = int'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      default:    v = 0;
    endcase
    return 32'(v);
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_decode(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    logic [31:0] imm;
    instruction_in = inst;
    PC_in          = pc;
    #1;
    imm = ref_imm(inst);
    chk({tag, ".rd1"}, Read_data1, model_rf[inst[19:15]]);
    chk({tag, ".rd2"}, Read_data2, model_rf[inst[24:20]]);
    chk({tag, ".imm"}, Immediate, imm);
    chk({tag, ".ctl"}, {24'd0, Ctl_RegWrite_out, Ctl_ALUSrc_out, Ctl_MemRead_out,
                        Ctl_MemWrite_out, Ctl_MemtoReg_out, Ctl_Branch_out, Ctl_ALUOp_out},
        {24'd0, ref_ctl(inst)});
    chk({tag, ".fields"}, {19'd0, Rd, Funct3, Funct7_5, 4'd0}, {19'd0, inst[11:7], inst[14:12], inst[30], 4'd0});
    chk({tag, ".pc"}, PC_out, pc);
`ifdef ID_BRANCH_TARGET_EN
    chk({tag, ".bt"}, Branch_target, pc + imm);
`endif
  endtask

  // driver: issue one write-back, checking old value before and new value after the falling edge
  task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
    @(posedge clk);
    #1;
    Ctl_RegWrite_in = 1'b1;
    WriteReg        = idx;
    WriteData       = data;
    instruction_in  = {12'd0, idx, 3'd0, 5'd0, 7'b0010011};
    #1;
    chk("wr.old", Read_data1, model_rf[idx]);
    @(negedge clk);
    #1;
    if (idx != 5'd0) model_rf[idx] = data;
    chk("wr.new", Read_data1, model_rf[idx]);
    Ctl_RegWrite_in = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 32; r++) begin
      instruction_in = {12'd0, 5'(r), 3'd0, 5'd0, 7'b0010011};
      #1;
      chk(tag, Read_data1, 32'd0);
    end
  endtask

  initial begin
    logic [6:0]  op_tab [7];
    logic [31:0] inst;
    op_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0000000};
    for (int r = 0; r < 32; r++) model_rf[r] = '0;
    reset = 1'b1; Ctl_RegWrite_in = 1'b0; WriteReg = '0; WriteData = '0;
    PC_in = '0; instruction_in = '0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset.regs");

    for (int r = 1; r <= 15; r++) do_write(5'(r), 32'(r + 2));
    do_write(5'd0, 32'hDEAD_BEEF);
    check_decode("x0", 32'h0000_0013, 32'd0);
    chk("x0.read", Read_data1, 32'd0);

    check_decode("add", 32'h0020_8533, 32'd0);
    chk("add.rd1", Read_data1, 32'd3);
    chk("add.rd2", Read_data2, 32'd4);
    chk("add.aluop", {30'd0, Ctl_ALUOp_out}, 32'd2);
    check_decode("sub", 32'h40A5_8633, 32'd4);
    chk("sub.rd1", Read_data1, 32'd13);
    chk("sub.rd2", Read_data2, 32'd12);
    chk("sub.f75", {31'd0, Funct7_5}, 32'd1);
    check_decode("addi", 32'h0040_0513, 32'd8);
    chk("addi.imm", Immediate, 32'd4);
    check_decode("lw", 32'h0061_AF83, 32'd12);
    chk("lw.rd1", Read_data1, 32'd5);
    chk("lw.imm", Immediate, 32'd6);
    check_decode("sw", 32'h00C0_24A3, 32'd16);
    chk("sw.rd2", Read_data2, 32'd14);
    chk("sw.imm", Immediate, 32'd9);
    check_decode("beq", 32'h0062_8463, 32'd20);
    chk("beq.rd1", Read_data1, 32'd7);
    chk("beq.imm", Immediate, 32'd8);
`ifdef ID_BRANCH_TARGET_EN
    chk("beq.target", Branch_target, 32'd28);
`endif
    check_decode("beq_neg", 32'hFE62_8EE3, 32'd20);
    chk("beq_neg.imm", Immediate, 32'hFFFF_FFFC);
    check_decode("unk0", 32'h0000_0000, 32'd0);
    check_decode("unk1", 32'hFFFF_FFFF, 32'd0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(5'($urandom_range(0, 31)), $urandom);
      inst = $urandom;
      inst[6:0] = op_tab[$urandom_range(0, 6)];
      check_decode("rand", inst, $urandom);
    end

    // reset mid-run with a colliding write: reset must win
    @(posedge clk);
    #1;
    reset = 1'b1; Ctl_RegWrite_in = 1'b1; WriteReg = 5'd5; WriteData = 32'h1234_5678;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0; Ctl_RegWrite_in = 1'b0;
    for (int r = 0; r < 32; r++) model_rf[r] = '0;
    check_all_zero("midreset.regs");
    check_decode("post_reset", 32'h0062_8463, 32'd100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
